// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the
// helper that tells multi-cycle (multiply/divide) opcodes apart.
package alu_pkg;

    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_PASS_T = 5'h01;
    localparam logic [4:0] FS_ADD    = 5'h02;
    localparam logic [4:0] FS_ADDU   = 5'h03;
    localparam logic [4:0] FS_SUB    = 5'h04;
    localparam logic [4:0] FS_SUBU   = 5'h05;
    localparam logic [4:0] FS_SLT    = 5'h06;
    localparam logic [4:0] FS_SLTU   = 5'h07;
    localparam logic [4:0] FS_AND    = 5'h08;
    localparam logic [4:0] FS_OR     = 5'h09;
    localparam logic [4:0] FS_XOR    = 5'h0A;
    localparam logic [4:0] FS_NOR    = 5'h0B;
    localparam logic [4:0] FS_SLL    = 5'h0C;
    localparam logic [4:0] FS_SRL    = 5'h0D;
    localparam logic [4:0] FS_SRA    = 5'h0E;
    localparam logic [4:0] FS_INC    = 5'h0F;
    localparam logic [4:0] FS_DEC    = 5'h10;
    localparam logic [4:0] FS_MULU   = 5'h1C;
    localparam logic [4:0] FS_DIVU   = 5'h1D;
    localparam logic [4:0] FS_MUL    = 5'h1E;
    localparam logic [4:0] FS_DIV    = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Opcodes 0x1C..0x1F are the iterative multiply/divide group.
    function automatic logic is_multi(input logic [4:0] fs);
        return (fs[4:2] == 3'b111);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the register-file read side and the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       FS;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] T;
    logic [WIDTH-1:0] y_hi;
    logic [WIDTH-1:0] y_lo;
    logic             n;
    logic             z;
    logic             v;
    logic             c;
    logic             busy;
    logic             done;

    modport master (output start, FS, S, T,
                    input  y_hi, y_lo, n, z, v, c, busy, done);
    modport slave  (input  start, FS, S, T,
                    output y_hi, y_lo, n, z, v, c, busy, done);
endinterface

// File: rtl/seq_mul_div.sv
// Iterative unsigned core: shift-add multiply or restoring divide on operand
// magnitudes, one bit per cycle. Signs are restored by the caller.
module seq_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_run,
    input  logic             i_signed,
    input  logic             i_op,      // 0 = multiply, 1 = divide
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_last
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;

    // Magnitudes at load, plus one multiply step and one divide step.
    always_comb begin
        w_a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
        w_b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
        w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_b});
    end

    // Iteration counter and latched operation select.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_op  <= 1'b0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_op  <= i_op;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Datapath: hi = partial product / remainder, lo = multiplier / quotient.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_hi <= '0;
            r_lo <= w_a_mag;
            r_b  <= w_b_mag;
        end else if (i_run) begin
            if (!r_op) begin
                r_hi <= w_madd[WIDTH:1];
                r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
            end else begin
                // Remainder stays below the divisor, so a WIDTH-bit difference is exact.
                r_hi <= w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = (r_cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops complete in IDLE, multiply/divide run
// through the iterative core and get their signs restored in FIX.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_load;
    logic [4:0]              r_op;
    logic [WIDTH-1:0]        r_s;
    logic [WIDTH-1:0]        r_t;
    logic [WIDTH-1:0]        r_y_hi;
    logic [WIDTH-1:0]        r_y_lo;
    logic                    r_n, r_z, r_v, r_c, r_done;
    logic [WIDTH-1:0]        w_md_hi;
    logic [WIDTH-1:0]        w_md_lo;
    logic                    w_md_last;
    logic [WIDTH-1:0]        w_b;
    logic                    w_cin, w_arith, w_ovf_op;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH-1:0]        w_alu;
    logic [SHW-1:0]          w_sh;
    logic signed [WIDTH-1:0] w_s_sgn;
    logic signed [WIDTH-1:0] w_t_sgn;
    logic                    w_sgn_op, w_neg_s, w_neg_t;
    logic [2*WIDTH-1:0]      w_prod;
    logic [WIDTH-1:0]        w_quo, w_rem;
    logic                    w_wr_single, w_wr_multi;
    logic [WIDTH-1:0]        w_y_hi, w_y_lo;
    logic                    w_n, w_z, w_v, w_c;

    seq_mul_div #(.WIDTH(WIDTH)) u_md (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_run    (r_state == ST_RUN),
        .i_signed (bus.FS[1]),
        .i_op     (bus.FS[0]),
        .i_a      (bus.S),
        .i_b      (bus.T),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo),
        .o_last   (w_md_last)
    );

    // FSM next state; a mul/div start in IDLE loads the iterative core.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.start && is_multi(bus.FS)) begin
                w_load      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN:  if (w_md_last) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Opcode and original operands kept for the sign fix-up.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_op <= bus.FS;
            r_s  <= bus.S;
            r_t  <= bus.T;
        end
    end

    // Single-cycle datapath; all add/sub forms share one adder S + B + cin.
    always_comb begin
        w_b      = '0;
        w_cin    = 1'b0;
        w_arith  = 1'b0;
        w_ovf_op = 1'b0;
        w_s_sgn  = bus.S;
        w_t_sgn  = bus.T;
        w_sh     = bus.T[SHW-1:0];
        case (bus.FS)
            FS_ADD:  begin w_b = bus.T;  w_arith = 1'b1; w_ovf_op = 1'b1; end
            FS_ADDU: begin w_b = bus.T;  w_arith = 1'b1; end
            FS_SUB:  begin w_b = ~bus.T; w_cin = 1'b1; w_arith = 1'b1; w_ovf_op = 1'b1; end
            FS_SUBU: begin w_b = ~bus.T; w_cin = 1'b1; w_arith = 1'b1; end
            FS_INC:  begin w_cin = 1'b1; w_arith = 1'b1; w_ovf_op = 1'b1; end
            FS_DEC:  begin w_b = '1;     w_arith = 1'b1; w_ovf_op = 1'b1; end
            default: ;
        endcase
        w_sum = {1'b0, bus.S} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
        w_alu = '0;
        case (bus.FS)
            FS_PASS_S: w_alu = bus.S;
            FS_PASS_T: w_alu = bus.T;
            FS_ADD, FS_ADDU, FS_SUB, FS_SUBU, FS_INC, FS_DEC: w_alu = w_sum[WIDTH-1:0];
            FS_SLT:    w_alu = {{(WIDTH-1){1'b0}}, (w_s_sgn < w_t_sgn)};
            FS_SLTU:   w_alu = {{(WIDTH-1){1'b0}}, (bus.S < bus.T)};
            FS_AND:    w_alu = bus.S & bus.T;
            FS_OR:     w_alu = bus.S | bus.T;
            FS_XOR:    w_alu = bus.S ^ bus.T;
            FS_NOR:    w_alu = ~(bus.S | bus.T);
            FS_SLL:    w_alu = bus.S << w_sh;
            FS_SRL:    w_alu = bus.S >> w_sh;
            FS_SRA:    w_alu = $unsigned(w_s_sgn >>> w_sh);
            default:   w_alu = '0;
        endcase
    end

    // Sign fix-up and selection of the value/flags to write back.
    always_comb begin
        w_sgn_op    = (r_op == FS_MUL) || (r_op == FS_DIV);
        w_neg_s     = w_sgn_op & r_s[WIDTH-1];
        w_neg_t     = w_sgn_op & r_t[WIDTH-1];
        w_prod      = {w_md_hi, w_md_lo};
        if (w_neg_s ^ w_neg_t) w_prod = -w_prod;
        w_quo       = (w_neg_s ^ w_neg_t) ? -w_md_lo : w_md_lo;
        w_rem       = w_neg_s ? -w_md_hi : w_md_hi;
        w_wr_single = bus.start && (r_state == ST_IDLE) && !is_multi(bus.FS);
        w_wr_multi  = (r_state == ST_FIX);
        w_y_hi      = '0;
        w_y_lo      = w_alu;
        w_n         = w_alu[WIDTH-1];
        w_z         = (w_alu == '0);
        w_v         = w_ovf_op && (bus.S[WIDTH-1] == w_b[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != bus.S[WIDTH-1]);
        w_c         = w_arith & w_sum[WIDTH];
        if (w_wr_multi) begin
            w_c = 1'b0;
            if (!r_op[0]) begin
                w_y_hi = w_prod[2*WIDTH-1:WIDTH];
                w_y_lo = w_prod[WIDTH-1:0];
                w_n    = w_prod[2*WIDTH-1];
                w_z    = (w_prod == '0);
                w_v    = 1'b0;
            end else begin
                if (r_t == '0) begin
                    // Divide by zero: all-ones quotient, dividend as remainder.
                    w_y_lo = '1;
                    w_y_hi = r_s;
                    w_v    = 1'b1;
                end else begin
                    // MIN / -1 already yields MIN with zero remainder; only flag it.
                    w_y_lo = w_quo;
                    w_y_hi = w_rem;
                    w_v    = w_sgn_op && (r_s == MIN_VAL) && (r_t == '1);
                end
                w_n = w_y_lo[WIDTH-1];
                w_z = (w_y_lo == '0);
            end
        end
    end

    // Result and flag registers, written only on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y_hi <= '0;
            r_y_lo <= '0;
            r_n    <= 1'b0;
            r_z    <= 1'b0;
            r_v    <= 1'b0;
            r_c    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_wr_single | w_wr_multi;
            if (w_wr_single | w_wr_multi) begin
                r_y_hi <= w_y_hi;
                r_y_lo <= w_y_lo;
                r_n    <= w_n;
                r_z    <= w_z;
                r_v    <= w_v;
                r_c    <= w_c;
            end
        end
    end

    assign bus.y_hi = r_y_hi;
    assign bus.y_lo = r_y_lo;
    assign bus.n    = r_n;
    assign bus.z    = r_z;
    assign bus.v    = r_v;
    assign bus.c    = r_c;
    assign bus.done = r_done;
    assign bus.busy = (r_state != ST_IDLE);
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    int   idx;
    int   bcnt;
    int   ndone;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) i32 ();
    seq_alu_if #(.WIDTH(8))  i8 ();

    seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(i32));
    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(i8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, then watch edges until done; idx = edge index of done
    // relative to the start edge (-1 on timeout), bcnt = cycles busy was high.
    // inj > 0 raises a stray ADD start on edge (start + inj) of the 32-bit DUT.
    task automatic run(input bit w8, input logic [4:0] fs, input logic [31:0] s,
                       input logic [31:0] t, input int inj, output int oidx, output int obcnt);
        oidx  = -1;
        obcnt = 0;
        if (w8) begin
            i8.FS = fs; i8.S = s[7:0]; i8.T = t[7:0]; i8.start = 1'b1;
        end else begin
            i32.FS = fs; i32.S = s; i32.T = t; i32.start = 1'b1;
        end
        for (int e = 0; e < 100; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) begin
                i32.start = 1'b0; i8.start = 1'b0;
                i32.S = $urandom(); i32.T = $urandom();
                i8.S = 8'($urandom()); i8.T = 8'($urandom());
            end
            if (inj > 0 && e == inj - 1) begin i32.FS = FS_ADD; i32.start = 1'b1; end
            if (inj > 0 && e == inj) i32.start = 1'b0;
            obcnt += w8 ? int'(i8.busy) : int'(i32.busy);
            if (w8 ? i8.done : i32.done) begin
                oidx = e;
                break;
            end
        end
    endtask

    initial begin
        i32.start = 1'b0; i32.FS = '0; i32.S = '0; i32.T = '0;
        i8.start  = 1'b0; i8.FS  = '0; i8.S  = '0; i8.T  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y_lo", 64'(i32.y_lo), 64'h0);
        chk("rst_y_hi", 64'(i32.y_hi), 64'h0);
        chk("rst_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'h0);
        chk("rst_busy_done", 64'({i32.busy, i32.done}), 64'h0);

        // ADD 2+3 on the first edge after release
        @(negedge clk);
        reset = 1'b1;
        run(1'b0, FS_ADD, 32'd2, 32'd3, 0, idx, bcnt);
        chk("add_lat", 64'(idx), 64'd0);
        chk("add_y_lo", 64'(i32.y_lo), 64'd5);
        chk("add_busy", 64'(bcnt), 64'd0);
        @(posedge clk);
        #1;
        chk("add_done_pulse", 64'(i32.done), 64'd0);
        chk("add_hold", 64'(i32.y_lo), 64'd5);

        // Signed overflow, then SUBU back to back
        run(1'b0, FS_ADD, 32'h7FFF_FFFF, 32'h1, 0, idx, bcnt);
        chk("ovf_lat", 64'(idx), 64'd0);
        chk("ovf_y_lo", 64'(i32.y_lo), 64'h8000_0000);
        chk("ovf_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'hA);
        run(1'b0, FS_SUBU, 32'd5, 32'd5, 0, idx, bcnt);
        chk("subu_lat", 64'(idx), 64'd0);
        chk("subu_y_lo", 64'(i32.y_lo), 64'h0);
        chk("subu_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'h5);
        run(1'b0, FS_SUB, 32'd3, 32'd5, 0, idx, bcnt);
        chk("sub_y_lo", 64'(i32.y_lo), 64'hFFFF_FFFE);
        chk("sub_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'h8);
        run(1'b0, FS_SLT, 32'hFFFF_FFFF, 32'd1, 0, idx, bcnt);
        chk("slt_y_lo", 64'(i32.y_lo), 64'd1);
        run(1'b0, FS_SLTU, 32'hFFFF_FFFF, 32'd1, 0, idx, bcnt);
        chk("sltu_y_lo", 64'(i32.y_lo), 64'd0);
        run(1'b0, 5'h11, 32'h1234, 32'h5678, 0, idx, bcnt);
        chk("undef_y", 64'({i32.y_hi, i32.y_lo}), 64'h0);
        chk("undef_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'h4);
        run(1'b0, FS_XOR, 32'hF0F0_0000, 32'h0FF0_0001, 0, idx, bcnt);
        chk("xor_y_lo", 64'(i32.y_lo), 64'hFF00_0001);

        // Reset while idle clears the held result
        #2;
        reset = 1'b0;
        #1;
        chk("idle_rst_y_lo", 64'(i32.y_lo), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // MUL with a stray start at k+5
        run(1'b0, FS_MUL, 32'hFFFF_FFFD, 32'd7, 5, idx, bcnt);
        chk("mul_lat", 64'(idx), 64'd33);
        chk("mul_busy_cycles", 64'(bcnt), 64'd33);
        chk("mul_busy_at_done", 64'(i32.busy), 64'd0);
        chk("mul_y", 64'({i32.y_hi, i32.y_lo}), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'h8);

        // Divides, each started in the done cycle of the previous op
        run(1'b0, FS_DIV, 32'hFFFF_FFF9, 32'd2, 0, idx, bcnt);
        chk("div_lat", 64'(idx), 64'd33);
        chk("div_y", 64'({i32.y_hi, i32.y_lo}), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'h8);
        run(1'b0, FS_DIVU, 32'd9, 32'd0, 0, idx, bcnt);
        chk("divz_lat", 64'(idx), 64'd33);
        chk("divz_y", 64'({i32.y_hi, i32.y_lo}), 64'h0000_0009_FFFF_FFFF);
        chk("divz_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'hA);
        run(1'b0, FS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, idx, bcnt);
        chk("divmin_y", 64'({i32.y_hi, i32.y_lo}), 64'h0000_0000_8000_0000);
        chk("divmin_flags", 64'({i32.n, i32.z, i32.v, i32.c}), 64'hA);

        // Reset during DIVU iteration 10 aborts with no writeback
        i32.FS = FS_DIVU; i32.S = 32'd100; i32.T = 32'd7; i32.start = 1'b1;
        @(posedge clk);
        #1;
        i32.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(i32.busy), 64'd0);
        chk("abort_y", 64'({i32.y_hi, i32.y_lo}), 64'h0);
        chk("abort_flags_done", 64'({i32.n, i32.z, i32.v, i32.c, i32.done}), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            ndone += int'(i32.done);
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run(1'b0, FS_ADD, 32'd10, 32'd20, 0, idx, bcnt);
        chk("post_abort_lat", 64'(idx), 64'd0);
        chk("post_abort_y_lo", 64'(i32.y_lo), 64'd30);

        // WIDTH=8 instance
        run(1'b1, FS_MULU, 32'hFF, 32'hFF, 0, idx, bcnt);
        chk("w8_mulu_lat", 64'(idx), 64'd9);
        chk("w8_mulu_busy", 64'(bcnt), 64'd9);
        chk("w8_mulu_y", 64'({i8.y_hi, i8.y_lo}), 64'hFE01);
        chk("w8_mulu_flags", 64'({i8.n, i8.z, i8.v, i8.c}), 64'h8);
        run(1'b1, FS_SRA, 32'h80, 32'd3, 0, idx, bcnt);
        chk("w8_sra_lat", 64'(idx), 64'd0);
        chk("w8_sra_y", 64'({i8.y_hi, i8.y_lo}), 64'h00F0);
        chk("w8_sra_flags", 64'({i8.n, i8.z, i8.v, i8.c}), 64'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the integer datapath, successor to the 32-bit combinational ALU. It executes single-cycle logic and arithmetic ops in one clock and runs signed and unsigned multiply and divide iteratively over WIDTH cycles. It uses a start/busy/done handshake, and all results and flags are held in registers. It sits between the register file read ports (S, T) and the writeback mux, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand width, even, minimum 8.
- `SHW`, default $clog2(WIDTH): shift-amount width, derived and not overridden.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only when `busy`=0.
- `FS`  in  5: opcode, sampled with `start`.
- `S`, `T`  in  WIDTH: operands, sampled with `start`.
- `y_hi`, `y_lo`  out  WIDTH: registered result.
- `n`, `z`, `v`, `c`  out  1: registered flags.
- `busy`  out  1: multiply or divide in progress.
- `done`  out  1: one-cycle pulse; results valid from this cycle and held until the next completion.

## Operation
- Opcodes:
  - 00 PASS_S, 01 PASS_T
  - 02 ADD, 03 ADDU, 04 SUB, 05 SUBU
  - 06 SLT, 07 SLTU
  - 08 AND, 09 OR, 0A XOR, 0B NOR
  - 0C SLL, 0D SRL, 0E SRA (shift amount = T[SHW-1:0])
  - 0F INC S, 10 DEC S
  - 1C MULU, 1D DIVU, 1E MUL, 1F DIV
  - Any other code: y_hi = y_lo = 0, z=1, all other flags 0.
- Single-cycle ops: result goes to y_lo and y_hi = 0.
- SUB is computed as S + ~T + 1. c = carry out of the MSB for ADD, ADDU, SUB, SUBU, INC and DEC; otherwise c = 0.
- v = signed overflow for ADD, SUB, INC and DEC; 0 for the unsigned forms and for the logic ops.
- n = MSB of y_lo for single-cycle ops and DIV/DIVU, MSB of y_hi for MUL/MULU. z = all result bits zero, where the result is {y_hi,y_lo} for MUL/MULU, the quotient for DIV/DIVU, and y_lo otherwise.
- MUL/MULU: full 2·WIDTH product in {y_hi,y_lo}.
- DIV/DIVU: y_lo = quotient, y_hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: y_lo = all ones, y_hi = S, v=1.
  - DIV MIN/−1: y_lo = MIN, y_hi = 0, v=1.
- Multiply and divide work on magnitudes: the core runs unsigned shift-add or restoring divide, then a final sign fix-up.
- States:
  - IDLE → RUN when `start` with a mul/div opcode.
  - RUN → FIX after WIDTH iterations.
  - FIX → IDLE, writing the outputs.
  - A single-cycle op stays in IDLE and writes the outputs directly.
- Operands and opcode are latched at `start`; input changes after that edge are ignored.
- `start` while `busy`=1 is ignored. It is not queued.

## Timing
- Reset (asynchronous, any state): state = IDLE; y_hi, y_lo, n, z, v, c, busy and done all 0. An operation in flight is aborted with no partial writeback.
- Single-cycle op: `start` is sampled at edge k. Outputs update and `done`=1 in cycle k..k+1, with `busy` staying 0. Back-to-back starts on consecutive edges are allowed and give one `done` per op.
- Mul/div: `start` at edge k sets `busy`=1. Iterations run at edges k+1..k+WIDTH, and the fix-up is at edge k+WIDTH+1. Outputs and `done`=1 appear after edge k+WIDTH+1, at which point `busy`=0.
  - Latency is WIDTH+1 cycles and `busy` is high for WIDTH+1 cycles.
  - A new `start` is accepted in the same cycle that `done` is high.
- Outputs are stable between `done` pulses; no intermediate values appear.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams (FS_ADD … FS_DIV)
  - state encoding (ST_IDLE, ST_RUN, ST_FIX)
  - the function `is_multi(FS)`.
- Sub-module `seq_mul_div`, parametrised by WIDTH:
  - iteration counter, partial-product and remainder registers
  - ports: load, signed, op, operands; outputs hi, lo, last.
- Top level `seq_alu` holds the combinational single-cycle datapath, the FSM, the output and flag registers, and the sign fix-up.

## Test plan
- Reset asserted mid-idle, then released → all outputs 0. A `start` with ADD 2+3 on the first edge after release → y_lo=5 with `done` one cycle later.
- ADD 0x7FFFFFFF + 0x00000001 → y_lo=0x80000000, n=1, v=1, c=0, z=0, `done` one cycle after `start`. SUBU 5−5 → y_lo=0, z=1, c=1.
- MUL 0xFFFFFFFD × 0x00000007 → y_hi=0xFFFFFFFF, y_lo=0xFFFFFFEB, n=1. `busy` is high for 33 cycles and `done` comes at edge k+33. A `start` issued at k+5 is ignored.
- DIV −7/2 → y_lo=0xFFFFFFFD, y_hi=0xFFFFFFFF. DIVU 9/0 → y_lo=0xFFFFFFFF, y_hi=9, v=1. DIV 0x80000000/−1 → y_lo=0x80000000, y_hi=0, v=1.
- Reset asserted during DIVU iteration 10 → busy=0, outputs 0, no `done` pulse. ADD issued after release completes normally.
- WIDTH=8: MULU 0xFF×0xFF → y_hi=0xFE, y_lo=0x01, latency 9. SRA 0x80 by 3 → 0xF0.
